// File: rtl/composite_video_pkg.sv
// Shared composite video timing constants, DAC levels and line-type encoding.
// Used by the sync generator and the sync separator.
package composite_video_pkg;

   typedef enum logic [1:0] {
      NORMAL = 2'd0,
      EQ     = 2'd1,
      VSYNC  = 2'd2
   } line_type_e;

   localparam int LINE_SAMPLES    = 2350;
   localparam int HSYNC_WIDTH     = 175;
   localparam int BACK_PORCH      = 175;
   localparam int ACTIVE_WIDTH    = 1920;
   localparam int LINES_PER_FRAME = 262;
   localparam int VBLANK_LINES    = 20;
   localparam int ACTIVE_LINES    = 240;

   localparam int SYNC_LEVEL  = 2600;
   localparam int BLANK_LEVEL = 3000;

endpackage

// File: rtl/video_timing_counter.sv
// Horizontal/vertical sample counters paced by sample_valid, plus line-type decode.
// Build option CSYNC_EQ_PULSES_EN selects the EQ-VSYNC-EQ vertical interval.
module video_timing_counter
   import composite_video_pkg::*;
#(
   parameter int LINE_SAMPLES    = composite_video_pkg::LINE_SAMPLES,
   parameter int LINES_PER_FRAME = composite_video_pkg::LINES_PER_FRAME
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sample_valid,
   output logic [11:0] h_cnt,
   output logic [8:0]  v_cnt,
   output line_type_e  line_type
);

   localparam logic [11:0] H_LAST = 12'(LINE_SAMPLES - 1);
   localparam logic [8:0]  V_LAST = 9'(LINES_PER_FRAME - 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (sample_valid) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 9'd0 : v_cnt + 9'd1;
         end else begin
            h_cnt <= h_cnt + 12'd1;
         end
      end
   end

   always_comb begin
      line_type = NORMAL;
`ifdef CSYNC_EQ_PULSES_EN
      if (v_cnt <= 9'd2 || (v_cnt >= 9'd6 && v_cnt <= 9'd8))
         line_type = EQ;
      else if (v_cnt <= 9'd5)
         line_type = VSYNC;
`else
      if (v_cnt <= 9'd2)
         line_type = VSYNC;
`endif
   end

endmodule

// File: rtl/composite_sync_gen.sv
// Composite sync/blanking/luma DAC code generator for a 262-line progressive frame.
// Define CSYNC_EQ_PULSES_EN to add equalizing pulses around vertical sync.
module composite_sync_gen
   import composite_video_pkg::*;
#(
   parameter int LINE_SAMPLES    = composite_video_pkg::LINE_SAMPLES,
   parameter int HSYNC_WIDTH     = composite_video_pkg::HSYNC_WIDTH,
   parameter int BACK_PORCH      = composite_video_pkg::BACK_PORCH,
   parameter int ACTIVE_WIDTH    = composite_video_pkg::ACTIVE_WIDTH,
   parameter int LINES_PER_FRAME = composite_video_pkg::LINES_PER_FRAME,
   parameter int VBLANK_LINES    = composite_video_pkg::VBLANK_LINES,
   parameter int ACTIVE_LINES    = composite_video_pkg::ACTIVE_LINES,
   parameter int SYNC_LEVEL      = composite_video_pkg::SYNC_LEVEL,
   parameter int BLANK_LEVEL     = composite_video_pkg::BLANK_LEVEL
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sample_valid,
   input  logic [11:0] pixel_data,
   output logic [11:0] dac_data,
   output logic        h_sync_pulse,
   output logic        v_sync_pulse,
   output logic        active_video,
   output logic [11:0] x_coord,
   output logic [8:0]  y_coord
);

   localparam logic [11:0] HALF      = 12'(LINE_SAMPLES / 2);
   localparam logic [11:0] HS        = 12'(HSYNC_WIDTH);
   localparam logic [11:0] HS_HALF   = 12'(HSYNC_WIDTH / 2);
   localparam logic [11:0] BROAD_END = 12'(LINE_SAMPLES / 2 - HSYNC_WIDTH);
   localparam logic [11:0] TAIL      = 12'(LINE_SAMPLES - HSYNC_WIDTH);
   localparam logic [11:0] ACT_START = 12'(HSYNC_WIDTH + BACK_PORCH);
   localparam logic [11:0] ACT_END   = 12'(HSYNC_WIDTH + BACK_PORCH + ACTIVE_WIDTH);
   localparam logic [8:0]  VA_START  = 9'(VBLANK_LINES);
   localparam logic [8:0]  VA_END    = 9'(VBLANK_LINES + ACTIVE_LINES);
   localparam logic [11:0] SYNC_CODE  = 12'(SYNC_LEVEL);
   localparam logic [11:0] BLANK_CODE = 12'(BLANK_LEVEL);

   logic [11:0] h_cnt;
   logic [8:0]  v_cnt;
   line_type_e  line_type;
   logic        sync_tip;
   logic        in_window;
   logic [11:0] dac_next;

   video_timing_counter #(
      .LINE_SAMPLES    (LINE_SAMPLES),
      .LINES_PER_FRAME (LINES_PER_FRAME)
   ) u_timing (
      .clk          (clk),
      .rst          (rst),
      .sample_valid (sample_valid),
      .h_cnt        (h_cnt),
      .v_cnt        (v_cnt),
      .line_type    (line_type)
   );

   always_comb begin
      sync_tip = 1'b0;
      case (line_type)
         NORMAL: sync_tip = (h_cnt < HS);
         EQ:     sync_tip = (h_cnt < HS_HALF) ||
                            (h_cnt >= HALF && h_cnt < HALF + HS_HALF);
         // Broad pulses: low except for the serration before mid-line and line end.
         VSYNC:  sync_tip = !((h_cnt >= BROAD_END && h_cnt < HALF) || h_cnt >= TAIL);
         default: sync_tip = 1'b0;
      endcase

      in_window = (line_type == NORMAL) &&
                  (v_cnt >= VA_START) && (v_cnt < VA_END) &&
                  (h_cnt >= ACT_START) && (h_cnt < ACT_END);

      dac_next = BLANK_CODE;
      if (sync_tip)
         dac_next = SYNC_CODE;
      else if (in_window)
         dac_next = (pixel_data > BLANK_CODE) ? pixel_data : BLANK_CODE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dac_data     <= BLANK_CODE;
         active_video <= 1'b0;
         x_coord      <= '0;
         y_coord      <= '0;
         h_sync_pulse <= 1'b0;
         v_sync_pulse <= 1'b0;
      end else begin
         h_sync_pulse <= 1'b0;
         v_sync_pulse <= 1'b0;
         if (sample_valid) begin
            dac_data     <= dac_next;
            active_video <= in_window;
            x_coord      <= h_cnt;
            y_coord      <= v_cnt;
            h_sync_pulse <= (h_cnt == 12'd0);
            v_sync_pulse <= (h_cnt == 12'd0) && (v_cnt == 9'd0);
         end
      end
   end

endmodule
